// File: rtl/corr_pkg.sv
// Shared definitions for the correlation datapath (sample multiplier and
// accumulating adder). Holds the default framing sizes that both stages
// must agree on, the derived product width, and the multiplier FSM states.
package corr_pkg;

  localparam int A_SAMPLES_DEF = 20;    // template length, products per window
  localparam int B_SAMPLES_DEF = 5000;  // record length
  localparam int SAMPLE_W_DEF  = 8;     // unsigned sample width
  localparam int PROD_W        = 2 * SAMPLE_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_ACK,
    S_DONE
  } mult_state_t;

endpackage

// File: rtl/window_index_counter.sv
// Sweep index bookkeeping for the sample multiplier.
//   i       : position inside the template (drives ROM A address directly)
//   k       : window offset into the record
//   b_addr  : ROM B address, tracked as its own counter so that k+i is never
//             formed with an adder on the address path
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           return i, k, b_addr to zero (has priority over advance)
//   advance         step to the next product of the sweep
//   i, b_addr       current indices
//   last_in_window  i is the final template sample
//   last_window     k is the final window
module window_index_counter
  import corr_pkg::*;
#(
  parameter int A_SAMPLES = A_SAMPLES_DEF,
  parameter int B_SAMPLES = B_SAMPLES_DEF,
  parameter int A_ADDR_W  = 5,
  parameter int B_ADDR_W  = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                advance,
  output logic [A_ADDR_W-1:0] i,
  output logic [B_ADDR_W-1:0] b_addr,
  output logic                last_in_window,
  output logic                last_window
);

  localparam logic [A_ADDR_W-1:0] I_LAST = A_ADDR_W'(A_SAMPLES - 1);
  localparam logic [B_ADDR_W-1:0] K_LAST = B_ADDR_W'(B_SAMPLES - A_SAMPLES - 1);

  logic [B_ADDR_W-1:0] k;
  logic [B_ADDR_W-1:0] k_inc;

  assign k_inc          = k + 1'b1;
  assign last_in_window = (i == I_LAST);
  assign last_window    = (k == K_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      i      <= '0;
      k      <= '0;
      b_addr <= '0;
    end else if (advance) begin
      if (last_in_window) begin
        // New window: the record address restarts at the new offset.
        i      <= '0;
        k      <= k_inc;
        b_addr <= k_inc;
      end else begin
        i      <= i + 1'b1;
        b_addr <= b_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_multiplier.sv
// Upstream stage of the correlation datapath. Walks template A across record
// B, fetching one sample pair per product from two synchronous ROMs and
// handing the unsigned product A[i]*B[k+i] to the accumulating adder over
// the ena/next_add handshake. One product is in flight at a time.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a sweep (ignored unless idle)
//   a_addr / a_data   ROM A address (registered) / data one cycle later
//   b_addr / b_data   ROM B address (registered) / data one cycle later
//   data              registered product, held until acknowledged
//   ena               one-cycle product-valid pulse
//   next_add          adder acknowledge (only honoured while waiting for it)
//   busy              sweep in progress
//   done              one-cycle pulse after the final acknowledge
module sample_multiplier
  import corr_pkg::*;
#(
  parameter int A_SAMPLES = A_SAMPLES_DEF,
  parameter int B_SAMPLES = B_SAMPLES_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int A_ADDR_W  = 5,
  parameter int B_ADDR_W  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [A_ADDR_W-1:0]   a_addr,
  input  logic [SAMPLE_W-1:0]   a_data,
  output logic [B_ADDR_W-1:0]   b_addr,
  input  logic [SAMPLE_W-1:0]   b_data,
  output logic [2*SAMPLE_W-1:0] data,
  output logic                  ena,
  input  logic                  next_add,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = 2 * SAMPLE_W;

  mult_state_t state, state_nxt;
  logic        ack;
  logic        sweep_end;
  logic        clear;
  logic        advance;
  logic        last_in_window;
  logic        last_window;

  // Acks outside WAIT_ACK are dropped so they can never move the counters.
  assign ack       = (state == S_WAIT_ACK) && next_add;
  assign sweep_end = ack && last_in_window && last_window;
  // The final ack clears instead of advancing, so addresses are back at zero
  // by the time the FSM returns to IDLE.
  assign clear     = (state == S_IDLE) || sweep_end;
  assign advance   = ack && !sweep_end;

  window_index_counter #(
    .A_SAMPLES (A_SAMPLES),
    .B_SAMPLES (B_SAMPLES),
    .A_ADDR_W  (A_ADDR_W),
    .B_ADDR_W  (B_ADDR_W)
  ) u_idx (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .advance        (advance),
    .i              (a_addr),
    .b_addr         (b_addr),
    .last_in_window (last_in_window),
    .last_window    (last_window)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start) state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_WAIT_RD;
      S_WAIT_RD:  state_nxt = S_ISSUE;
      S_ISSUE:    state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (ack) state_nxt = sweep_end ? S_DONE : S_FETCH;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // exactly with the state they describe and carry no decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      ena  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      ena  <= (state_nxt == S_ISSUE);
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_DONE);
    end
  end

  // ROM data is valid in WAIT_RD; the product is then held until the next
  // WAIT_RD, which covers ISSUE and the whole ack wait.
  always_ff @(posedge clk) begin
    if (rst)                     data <= '0;
    else if (state == S_WAIT_RD) data <= PW'(a_data) * PW'(b_data);
  end

endmodule

// File: tb/tb_sample_multiplier.sv
module tb_sample_multiplier;

  localparam int NA = 20;

  typedef struct {
    logic [15:0] d;
    logic [4:0]  a;
    logic [12:0] b;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [4:0]  a_addr;
  logic [12:0] b_addr;
  logic [7:0]  a_data, b_data;
  logic [15:0] data;
  logic        ena, busy, done, next_add;
  logic        model_ack = 0, force_ack = 0;

  logic        s_start = 0;
  logic [1:0]  s_a_addr;
  logic [2:0]  s_b_addr;
  logic [7:0]  s_a_data, s_b_data;
  logic [15:0] s_data;
  logic        s_ena, s_busy, s_done, s_next_add = 0;

  int checks = 0, errors = 0;
  int cyc = 0, mode = 0, ack_delay = 0, ack_cnt = 0;
  int ena_cnt = 0, s_ena_cnt = 0, s_done_cnt = 0;
  int s_last_b = -1;
  logic ena_prev = 0;
  logic [15:0] last_data = 0;
  exp_t q[$];
  logic [15:0] s_q[$];
  logic [15:0] got[$];
  int ena_cyc[$];

  always #5 clk = ~clk;
  assign next_add = model_ack | force_ack;

  sample_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .a_addr(a_addr), .a_data(a_data),
    .b_addr(b_addr), .b_data(b_data), .data(data), .ena(ena),
    .next_add(next_add), .busy(busy), .done(done));

  sample_multiplier #(.A_SAMPLES(3), .B_SAMPLES(8), .A_ADDR_W(2), .B_ADDR_W(3)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .a_addr(s_a_addr), .a_data(s_a_data),
    .b_addr(s_b_addr), .b_data(s_b_data), .data(s_data), .ena(s_ena),
    .next_add(s_next_add), .busy(s_busy), .done(s_done));

  function automatic int a_val(int m, int idx);
    return (m == 1) ? 255 : 1;
  endfunction
  function automatic int b_val(int m, int n);
    return (m == 1) ? 255 : (n % 256);
  endfunction

  // Synchronous ROMs
  always @(posedge clk) begin
    a_data   <= 8'(a_val(mode, int'(a_addr)));
    b_data   <= 8'(b_val(mode, int'(b_addr)));
    s_a_data <= 8'd1;
    s_b_data <= 8'(s_b_addr);
  end

  // Adder model: registered ack, optionally delayed by ack_delay cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    model_ack  <= 1'b0;
    s_next_add <= rst ? 1'b0 : s_ena;
    if (rst) ack_cnt <= 0;
    else if (ena) begin
      if (ack_delay == 0) model_ack <= 1'b1;
      else ack_cnt <= ack_delay;
    end else if (ack_cnt > 0) begin
      if (ack_cnt == 1) model_ack <= 1'b1;
      ack_cnt <= ack_cnt - 1;
    end
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    exp_t e;
    if (ena) begin
      ena_cnt++;
      ena_cyc.push_back(cyc);
      checks++;
      if (ena_prev) begin
        errors++;
        $display("FAIL ena_width: ena high two cycles at cycle %0d", cyc);
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ena: data=%0d a=%0d b=%0d, none expected", data, a_addr, b_addr);
      end else begin
        e = q.pop_front();
        if ({data, a_addr, b_addr} !== {e.d, e.a, e.b}) begin
          errors++;
          $display("FAIL product: got d=%0d a=%0d b=%0d, want d=%0d a=%0d b=%0d",
                   data, a_addr, b_addr, e.d, e.a, e.b);
        end
      end
      got.push_back(data);
      last_data = data;
    end
    if (model_ack) begin
      checks++;
      if (data !== last_data) begin
        errors++;
        $display("FAIL data_hold: data=%0d at ack, issued %0d", data, last_data);
      end
    end
    ena_prev = ena;
    if (s_ena) begin
      s_ena_cnt++;
      s_last_b = int'(s_b_addr);
      checks++;
      if (s_q.size() == 0 || s_data !== s_q[0]) begin
        errors++;
        $display("FAIL small_product: got %0d, want %0d", s_data, (s_q.size() != 0) ? s_q[0] : 16'hxxxx);
      end
      if (s_q.size() != 0) void'(s_q.pop_front());
    end
    if (s_done) s_done_cnt++;
  end

  task automatic push_prods(input int m, input int k0, input int k1);
    for (int k = k0; k <= k1; k++)
      for (int i = 0; i < NA; i++)
        q.push_back('{d: 16'(a_val(m, i) * b_val(m, k + i)), a: 5'(i), b: 13'(k + i)});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  // Returns #1 after the posedge following the last expected ISSUE cycle
  task automatic wait_empty(input int bound, input string name);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d products still pending", name, q.size());
      q.delete();
    end
  endtask

  task automatic reset_now();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (data !== 16'd0)  begin errors++; $display("FAIL reset_data: got %0d want 0", data); end
    checks++; if (ena !== 1'b0)    begin errors++; $display("FAIL reset_ena: got %b want 0", ena); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (a_addr !== 5'd0) begin errors++; $display("FAIL reset_a_addr: got %0d want 0", a_addr); end
    checks++; if (b_addr !== 13'd0) begin errors++; $display("FAIL reset_b_addr: got %0d want 0", b_addr); end
    rst = 0;
  endtask

  task automatic test_ramp();
    int s0 = 0, s1 = 0;
    mode = 0; ack_delay = 0; got.delete();
    push_prods(0, 0, 1);
    pulse_start();
    wait_empty(400, "ramp");
    reset_now();
    for (int n = 0; n < got.size(); n++)
      if (n < NA) s0 += int'(got[n]); else s1 += int'(got[n]);
    checks++; if (s0 != 190) begin errors++; $display("FAIL window0_sum: got %0d want 190", s0); end
    checks++; if (s1 != 210) begin errors++; $display("FAIL window1_sum: got %0d want 210", s1); end
  endtask

  task automatic test_max();
    mode = 1; ack_delay = 0; got.delete();
    push_prods(1, 0, 1);
    pulse_start();
    wait_empty(400, "max");
    reset_now();
    checks++;
    if (got.size() != 40 || got[39] !== 16'hFE01) begin
      errors++; $display("FAIL max_product: got %0d items, last %h, want 40 items of fe01", got.size(), got.size() ? got[got.size()-1] : 16'h0);
    end
  endtask

  task automatic test_ack_delay();
    mode = 0; ack_delay = 10; ena_cyc.delete();
    for (int i = 0; i < 6; i++) q.push_back('{d: 16'(i), a: 5'(i), b: 13'(i)});
    pulse_start();
    wait_empty(200, "ack_delay");
    reset_now();
    ack_delay = 0;
    checks++;
    if (ena_cyc.size() != 6) begin
      errors++; $display("FAIL ack_delay_count: got %0d ena pulses, want 6", ena_cyc.size());
    end else
      for (int n = 1; n < 6; n++) begin
        checks++;
        if (ena_cyc[n] - ena_cyc[n-1] != 14) begin
          errors++; $display("FAIL ack_delay_period: got %0d cycles, want 14", ena_cyc[n] - ena_cyc[n-1]);
        end
      end
  endtask

  task automatic test_spurious();
    int e0 = ena_cnt;
    mode = 0;
    repeat (2) @(negedge clk);
    force_ack = 1;
    repeat (3) @(negedge clk);
    force_ack = 0;
    @(negedge clk);
    checks++; if (a_addr !== 5'd0 || b_addr !== 13'd0) begin
      errors++; $display("FAIL idle_ack_addr: got a=%0d b=%0d want 0 0", a_addr, b_addr); end
    checks++; if (ena_cnt != e0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_ack_ena: got %0d extra ena, busy=%b, want 0 0", ena_cnt - e0, busy); end
    for (int i = 0; i < 8; i++) q.push_back('{d: 16'(i), a: 5'(i), b: 13'(i)});
    pulse_start();
    repeat (6) @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_empty(200, "start_mid");
    reset_now();
  endtask

  task automatic test_small();
    int n = 0;
    s_ena_cnt = 0; s_done_cnt = 0; s_last_b = -1;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 3; i++) s_q.push_back(16'(k + i));
    @(negedge clk) s_start = 1;
    @(negedge clk) s_start = 0;
    while (!s_done && n < 200) begin @(negedge clk); n++; end
    checks++; if (!s_done) begin errors++; $display("FAIL small_done_timeout: done not seen in %0d cycles", n); end
    @(negedge clk);
    checks++; if (s_done !== 1'b0 || s_busy !== 1'b0) begin
      errors++; $display("FAIL small_done_pulse: done=%b busy=%b after done, want 0 0", s_done, s_busy); end
    repeat (4) @(negedge clk);
    checks++; if (s_ena_cnt != 15) begin errors++; $display("FAIL small_ena_count: got %0d want 15", s_ena_cnt); end
    checks++; if (s_last_b != 6) begin errors++; $display("FAIL small_last_b: got %0d want 6", s_last_b); end
    checks++; if (s_done_cnt != 1) begin errors++; $display("FAIL small_done_count: got %0d want 1", s_done_cnt); end
    checks++; if (s_a_addr !== 2'd0 || s_b_addr !== 3'd0) begin
      errors++; $display("FAIL small_final_addr: got a=%0d b=%0d want 0 0", s_a_addr, s_b_addr); end
  endtask

  task automatic test_reset_mid();
    mode = 0; ack_delay = 0;
    push_prods(0, 0, 6);
    pulse_start();
    wait_empty(1000, "reset_mid");
    @(posedge clk); #1;            // FETCH of window 7
    @(posedge clk); #1;            // WAIT_RD of window 7
    checks++; if (a_addr !== 5'd0 || b_addr !== 13'd7) begin
      errors++; $display("FAIL win7_addr: got a=%0d b=%0d want 0 7", a_addr, b_addr); end
    rst = 1;
    @(posedge clk); #1;
    checks++; if ({ena, busy, done, data, a_addr, b_addr} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: ena=%b busy=%b done=%b data=%0d a=%0d b=%0d, want all 0",
                         ena, busy, done, data, a_addr, b_addr); end
    rst = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) q.push_back('{d: 16'(i), a: 5'(i), b: 13'(i)});
    pulse_start();
    wait_empty(100, "restart");
    reset_now();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_max();
    test_ack_delay();
    test_spurious();
    test_small();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_multiplier.md
# sample_multiplier

Upstream stage of the correlation datapath: walks signal A (short template) across signal B (long record), reads one sample pair per product from two synchronous ROMs, and forms the unsigned product A[i]·B[k+i]. Products go one at a time to the accumulating adder over an ena/next_add handshake. The sweep order and counts match the adder's framing exactly: A_SAMPLES products per window, B_SAMPLES−A_SAMPLES windows.

## Interface
- A_SAMPLES, 20, samples in template A (products per window)
- B_SAMPLES, 5000, samples in record B
- SAMPLE_W, 8, unsigned sample width; product width is 2·SAMPLE_W = 16
- A_ADDR_W, 5, ROM A address width, ≥ clog2(A_SAMPLES)
- B_ADDR_W, 13, ROM B address width, ≥ clog2(B_SAMPLES)

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- a_addr  out  A_ADDR_W  ROM A read address, registered
- a_data  in  SAMPLE_W  ROM A data, valid one cycle after a_addr
- b_addr  out  B_ADDR_W  ROM B read address, registered
- b_data  in  SAMPLE_W  ROM B data, valid one cycle after b_addr
- data  out  16  product to the adder, registered
- ena  out  1  product valid; high for exactly one cycle per product
- next_add  in  1  adder acknowledge for the last product
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the final acknowledge

## Operation
- Counters: i (0..A_SAMPLES−1), k (0..B_SAMPLES−A_SAMPLES−1). Addresses are a_addr = i and b_addr = k+i. b_addr is kept as its own counter and is never formed with an adder.
- FSM states: IDLE, FETCH, WAIT_RD, ISSUE, WAIT_ACK, DONE.
- IDLE: i=k=0, a_addr=b_addr=0. On start, go to FETCH and set busy=1.
- FETCH: addresses are stable; the ROMs sample them at the end of the cycle. Go to WAIT_RD.
- WAIT_RD: a_data and b_data are valid. Register data = a_data·b_data. Go to ISSUE.
- ISSUE: ena=1 for this cycle only. Go to WAIT_ACK.
- WAIT_ACK: ena=0 and data is held. On next_add=1:
  - If i<A_SAMPLES−1: i++ and b_addr++.
  - Otherwise set i=0 and k++. b_addr becomes the new k.
  - If k was the last window: go to DONE. Otherwise go to FETCH.
  - With no next_add, stay in WAIT_ACK indefinitely.
- DONE: done=1 for one cycle, busy=0 on the following cycle, then IDLE.
- Arithmetic: unsigned SAMPLE_W×SAMPLE_W gives a full 2·SAMPLE_W product with no truncation. The maximum 255·255 = 65025 fits in 16 bits.
- Ignored inputs:
  - start while busy.
  - next_add in any state other than WAIT_ACK. A spurious ack must not advance the counters.
- Reset values: data=0, ena=0, busy=0, done=0, a_addr=0, b_addr=0, state IDLE, i=k=0.
- Reset mid-sweep returns to IDLE on the next edge with no further ena. The adder shares rst, so its partial sum is discarded too.

## Timing
- With start sampled at edge E0:
  - FETCH occupies cycle 1, WAIT_RD cycle 2, ISSUE cycle 3 (ena high).
  - The adder registers next_add, so it is seen in cycle 4 (WAIT_ACK), and FETCH follows in cycle 5.
- Steady state is 4 cycles per product when the adder acks immediately.
- Full default sweep: 4980·20 = 99 600 products, about 398 400 cycles plus 2 for DONE.
- If next_add is delayed N cycles, the product period stretches by N.
- ena never stays high across two consecutive cycles. The adder accumulates on every cycle ena is high, so this is mandatory.
- done asserts in the cycle after the final next_add is sampled.

## Structure
- Shared package `corr_pkg`:
  - FSM state enum.
  - Defaults for A_SAMPLES, B_SAMPLES and SAMPLE_W, which the adder also uses.
  - Derived PROD_W = 2·SAMPLE_W.
- One sub-module, `window_index_counter`:
  - Holds i, k and b_addr.
  - Inputs: advance and clear.
  - Outputs: last_in_window and last_window.
- The FSM and the product register stay in the top level.

## Test plan
- A[i]=1, B[n]=n mod 256, immediate-ack model: the first 20 products are 0..19 (window sum 190). The second window is 1..20 (sum 210).
- A[i]=255, B[n]=255: every product is 65025. No overflow, and data[15:0]=16'hFE01.
- Ack held off 10 cycles after each ena: exactly one ena pulse per product, data held stable throughout, product period 14 cycles.
- Small parameters A_SAMPLES=3, B_SAMPLES=8:
  - 5 windows, 15 ena pulses.
  - Last b_addr issued is 6.
  - done is a single pulse and busy then drops to 0.
- next_add pulsed while in IDLE, and start pulsed mid-sweep: counters and addresses unchanged, no extra ena.
- rst asserted in WAIT_RD of window 7: ena stays 0 and all outputs are 0 the next cycle. A following start restarts from a_addr=0, b_addr=0.
